// File: rtl/mod_ctrl_pkg.sv
// ============================================================================
// Module  : mod_ctrl_pkg
// Purpose : Shared definitions for the counter arbiter: FSM state encodings,
//           the modulus clamp function and the round-robin pick function.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mod_ctrl_pkg;

  localparam int unsigned ST_W = 2;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Widest requester vector rr_pick can scan.
  localparam int unsigned RR_MAX = 32;

  // Zero would never reach terminal count, so it is served as a 1-cycle interval.
  function automatic int unsigned clamp_load(input int unsigned value,
                                             input int unsigned maxload);
    if (value == 32'd0)
      return 32'd1;
    else if (value > maxload)
      return maxload;
    else
      return value;
  endfunction

  // First set request at or after ptr, wrapping modulo n. Returns ptr when
  // nothing is set; callers only use the result when some request is set.
  // The loop bound is constant so the scan unrolls to a fixed priority chain.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      idx = ptr + k;
      if (idx >= n)
        idx = idx - n;
      if ((k < n) && !found && req[idx[4:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_load_counter.sv
// ============================================================================
// Module  : mod_load_counter
// Purpose : CW-bit up counter with a latched modulus L. Counts 0..L-1 while
//           en is high and wraps to 0 on terminal count.
// Ports   : clk, reset_n (async, active-low)
//           load     - latch load_val as modulus and restart from 0
//           load_val - modulus to latch (already clamped to >= 1)
//           clr      - synchronous clear of the count
//           en       - count enable
//           cnt      - current count
//           tc       - terminal count: en && cnt == L-1
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_load_counter #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] modulus;

  assign tc = en && (cnt == (modulus - 1'b1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      modulus <= CW'(1);
    end else if (load) begin
      modulus <= load_val;
      cnt     <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter_arbiter.sv
// ============================================================================
// Module  : mod_counter_arbiter
// Purpose : Shares one programmable modulus counter between NREQ requesters
//           using round-robin arbitration. The owner's interval runs to
//           terminal count, then the owner receives a one-cycle done pulse.
// Ports   : clk, reset_n (async, active-low)
//           req    [NREQ]    - level requests, held until done or abort
//           load_i [NREQ*CW] - per-requester modulus, slice i at [i*CW +: CW]
//           enable           - count qualifier, low pauses the interval
//           gnt    [NREQ]    - one-hot owner while running, zero when free
//           count  [CW]      - current count of the running interval
//           busy             - high in RUN and DONE
//           done   [NREQ]    - one-cycle completion pulse to the owner
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_counter_arbiter
  import mod_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAXLOAD = 500,
  parameter int CW      = $clog2(MAXLOAD + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] load_i,
  input  logic               enable,
  output logic [NREQ-1:0]    gnt,
  output logic [CW-1:0]      count,
  output logic               busy,
  output logic [NREQ-1:0]    done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] owner;
  logic [IW-1:0] owner_inc;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic [NREQ-1:0] owner_oh;
  logic [CW-1:0] win_load;
  logic [CW-1:0] win_load_cl;
  logic          start;
  logic          abort;
  logic          cnt_en;
  logic          tc;

  // --------------------------------------------------------------------------
  // Arbitration and owner bookkeeping
  // --------------------------------------------------------------------------
  assign winner      = IW'(rr_pick(RR_MAX'(req), 32'(rr_ptr), NREQ));
  assign win_load    = load_i[winner*CW +: CW];
  assign win_load_cl = CW'(clamp_load(32'(win_load), MAXLOAD));
  assign owner_inc   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign owner_oh    = NREQ'(1) << owner;

  assign start  = (state == ST_IDLE) && (|req);
  // Abort is evaluated before terminal count: it gates the counter enable,
  // so tc can never fire in the same cycle as an abort.
  assign abort  = (state == ST_RUN) && !req[owner];
  assign cnt_en = (state == ST_RUN) && enable && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      if (start)
        owner <= winner;
      if (abort || (state == ST_DONE))
        rr_ptr <= owner_inc;
    end
  end

  // --------------------------------------------------------------------------
  // Shared counter; the modulus is captured only at grant time
  // --------------------------------------------------------------------------
  mod_load_counter #(
    .CW (CW)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start),
    .load_val (win_load_cl),
    .clr      (abort),
    .en       (cnt_en),
    .cnt      (count),
    .tc       (tc)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort)
          state_nxt = ST_IDLE;
        else if (tc)
          state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state and owner, so reset clears
  // them asynchronously)
  // --------------------------------------------------------------------------
  always_comb begin
    gnt  = '0;
    done = '0;
    busy = 1'b0;
    case (state)
      ST_RUN: begin
        gnt  = owner_oh;
        busy = 1'b1;
      end
      ST_DONE: begin
        done = owner_oh;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_arbiter.sv
// ============================================================================
// Module  : tb_mod_counter_arbiter
// Purpose : Directed self-checking bench for mod_counter_arbiter with
//           NREQ=4, MAXLOAD=500 (CW=9).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mod_counter_arbiter;

  localparam int NREQ    = 4;
  localparam int MAXLOAD = 500;
  localparam int CW      = 9;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] load_i;
  logic               enable;
  logic [NREQ-1:0]    gnt;
  logic [CW-1:0]      count;
  logic               busy;
  logic [NREQ-1:0]    done;

  int errors = 0;
  int checks = 0;

  mod_counter_arbiter #(
    .NREQ    (NREQ),
    .MAXLOAD (MAXLOAD),
    .CW      (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .load_i  (load_i),
    .enable  (enable),
    .gnt     (gnt),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_load(input int idx, input int value);
    load_i[idx*CW +: CW] = CW'(value);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " gnt"},  32'(gnt),  32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // Expects a grant to idx starting at the next negedge, len counting cycles,
  // the done cycle, then one idle cycle. req is replaced by req_after right
  // after the done cycle is observed.
  task automatic expect_interval(input string tag, input int idx, input int len,
                                 input logic [NREQ-1:0] req_after);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      check({tag, " gnt"},   32'(gnt),   32'(oh));
      check({tag, " count"}, 32'(count), 32'(c));
      check({tag, " busy"},  32'(busy),  32'd1);
      check({tag, " done"},  32'(done),  32'd0);
    end
    @(negedge clk);
    check({tag, " dgnt"},   32'(gnt),   32'd0);
    check({tag, " dpulse"}, 32'(done),  32'(oh));
    check({tag, " dbusy"},  32'(busy),  32'd1);
    check({tag, " dcount"}, 32'(count), 32'd0);
    req = req_after;
    @(negedge clk);
    check_quiet({tag, " idle"});
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    load_i  = '0;
    enable  = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset count", 32'(count), 32'd0);

    // 1: single requester, L=5
    reset_n = 1'b1;
    set_load(0, 5);
    req = 4'b0001;
    expect_interval("t1", 0, 5, 4'b0000);

    // 2: all requesting, L=2 each, after a fresh reset so rr_ptr starts at 0
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_load(i, 2);
    req = 4'b1111;
    expect_interval("t2 g0", 0, 2, 4'b1111);
    expect_interval("t2 g1", 1, 2, 4'b1111);
    expect_interval("t2 g2", 2, 2, 4'b1111);
    expect_interval("t2 g3", 3, 2, 4'b1111);
    expect_interval("t2 g0b", 0, 2, 4'b0000);

    // 3: clamp. rr_ptr=1. 511 is the largest value a 9-bit field holds and
    // is above MAXLOAD, so requester 2 runs 500 cycles.
    set_load(1, 0);
    set_load(2, 511);
    req = 4'b0110;
    expect_interval("t3 r1", 1, 1, 4'b0100);
    expect_interval("t3 r2", 2, 500, 4'b0000);

    // 4: pause at count 2 for 3 cycles; rr_ptr=3 wraps to requester 0.
    // load0 is changed after grant and must be ignored.
    set_load(0, 4);
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4 gnt", 32'(gnt), 32'd1);
      check("t4 count", 32'(count), 32'(c));
      if (c == 0) set_load(0, 9);
    end
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4 hold gnt", 32'(gnt), 32'd1);
      check("t4 hold count", 32'(count), 32'd2);
      check("t4 hold done", 32'(done), 32'd0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("t4 gnt3", 32'(gnt), 32'd1);
    check("t4 count3", 32'(count), 32'd3);
    @(negedge clk);
    check("t4 dgnt", 32'(gnt), 32'd0);
    check("t4 dpulse", 32'(done), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    check_quiet("t4 idle");

    // Short interval on requester 1 moves rr_ptr to 2
    set_load(1, 1);
    req = 4'b0010;
    expect_interval("t4b", 1, 1, 4'b0000);

    // 5: abort of requester 0 at count 3 of L=6; afterwards ptr must be 1,
    // so requester 1 beats requester 3.
    set_load(0, 6);
    set_load(1, 3);
    set_load(3, 2);
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5 gnt", 32'(gnt), 32'd1);
      check("t5 count", 32'(count), 32'(c));
      if (c == 0) req = 4'b1011;
    end
    req = 4'b1010;
    @(negedge clk);
    check_quiet("t5 abort");
    check("t5 abort count", 32'(count), 32'd0);
    expect_interval("t5 r1", 1, 3, 4'b0000);

    // 6: async reset mid-RUN, then arbitration restarts at index 0
    set_load(3, 10);
    req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t6 gnt", 32'(gnt), 32'd8);
      check("t6 count", 32'(count), 32'(c));
    end
    #2 reset_n = 1'b0;
    #1;
    check_quiet("t6 async");
    check("t6 async count", 32'(count), 32'd0);
    @(negedge clk);
    check_quiet("t6 held");
    reset_n = 1'b1;
    set_load(0, 2);
    req = 4'b1001;
    expect_interval("t6 r0", 0, 2, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
